// File: rtl/locked_adder_resp_checker.sv
// rtl/locked_adder_resp_checker.sv - response checker for locked-adder key-sweep windows
//
// Recomputes the golden sum for every accepted operand/result beat and, over a
// window of NVEC beats per key, accumulates mismatch count, total and worst
// per-vector Hamming distance. One summary record per window is offered on a
// valid/ready report port.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   start_i, key_i       open a window and latch its key (IDLE only)
//   in_valid_i/in_ready_o  beat handshake carrying add1_i, add2_i, result_i
//   rpt_valid_o/rpt_ready_i  summary handshake carrying rpt_key_o,
//                        rpt_vec_cnt_o, rpt_err_cnt_o, rpt_hd_sum_o, rpt_hd_max_o
//   busy_o               window open or report pending

module locked_adder_resp_checker #(
    parameter int WIDTH = 32,
    parameter int KEY_W = 64,
    parameter int NVEC  = 10001,
    parameter int CNT_W = 16,
    parameter int HD_W  = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [KEY_W-1:0]        key_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [WIDTH-1:0]        add1_i,
    input  logic [WIDTH-1:0]        add2_i,
    input  logic [WIDTH:0]          result_i,
    output logic                    rpt_valid_o,
    input  logic                    rpt_ready_i,
    output logic [KEY_W-1:0]        rpt_key_o,
    output logic [CNT_W-1:0]        rpt_vec_cnt_o,
    output logic [CNT_W-1:0]        rpt_err_cnt_o,
    output logic [CNT_W+HD_W-1:0]   rpt_hd_sum_o,
    output logic [HD_W-1:0]         rpt_hd_max_o,
    output logic                    busy_o
);

    localparam int SUM_W = CNT_W + HD_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state;
    logic [KEY_W-1:0]   key_q;
    logic [CNT_W-1:0]   vec_q;
    logic [CNT_W-1:0]   err_q;
    logic [SUM_W-1:0]   hd_sum_q;
    logic [HD_W-1:0]    hd_max_q;

    function automatic logic [HD_W-1:0] popcount(input logic [WIDTH:0] v);
        logic [HD_W-1:0] c;
        c = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            c = c + HD_W'(v[i]);
        end
        return c;
    endfunction

    logic               accept;
    logic [WIDTH:0]     golden;
    logic [HD_W-1:0]    hd;
    logic [CNT_W-1:0]   vec_next;
    logic [CNT_W-1:0]   err_next;
    logic [SUM_W:0]     sum_ext;
    logic [SUM_W-1:0]   hd_sum_next;
    logic [HD_W-1:0]    hd_max_next;

    // Handshake outputs are pure state decodes so that reset clears them
    // immediately and no input feeds an output combinationally.
    assign in_ready_o  = (state == RUN);
    assign rpt_valid_o = (state == REPORT);
    assign busy_o      = (state == RUN) || (state == REPORT);

    assign rpt_key_o     = key_q;
    assign rpt_vec_cnt_o = vec_q;
    assign rpt_err_cnt_o = err_q;
    assign rpt_hd_sum_o  = hd_sum_q;
    assign rpt_hd_max_o  = hd_max_q;

    always_comb begin
        accept      = in_valid_i && (state == RUN);
        golden      = {1'b0, add1_i} + {1'b0, add2_i};
        hd          = popcount(golden ^ result_i);
        // Saturating updates: counters clamp at all-ones instead of wrapping.
        vec_next    = (vec_q == '1) ? vec_q : vec_q + CNT_W'(1);
        err_next    = ((hd == '0) || (err_q == '1)) ? err_q : err_q + CNT_W'(1);
        sum_ext     = {1'b0, hd_sum_q} + (SUM_W+1)'(hd);
        hd_sum_next = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        hd_max_next = (hd > hd_max_q) ? hd : hd_max_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            key_q    <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            hd_sum_q <= '0;
            hd_max_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        key_q    <= key_i;
                        vec_q    <= '0;
                        err_q    <= '0;
                        hd_sum_q <= '0;
                        hd_max_q <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        vec_q    <= vec_next;
                        err_q    <= err_next;
                        hd_sum_q <= hd_sum_next;
                        hd_max_q <= hd_max_next;
                        if (vec_next == CNT_W'(NVEC)) begin
                            state <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    // Accumulators are left untouched so the record stays
                    // stable until it is taken and until the next window opens.
                    if (rpt_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_locked_adder_resp_checker.sv
// tb/tb_locked_adder_resp_checker.sv - directed self-checking bench for locked_adder_resp_checker
module tb_locked_adder_resp_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Main instance: NVEC=4, default widths
    logic        start = 1'b0;
    logic [63:0] key = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] add1 = '0;
    logic [31:0] add2 = '0;
    logic [32:0] result = '0;
    logic        rpt_valid;
    logic        rpt_ready = 1'b0;
    logic [63:0] rpt_key;
    logic [15:0] rpt_vec;
    logic [15:0] rpt_err;
    logic [21:0] rpt_sum;
    logic [5:0]  rpt_max;
    logic        busy;

    // Narrow instance: CNT_W=3, NVEC=7
    logic        s_start = 1'b0;
    logic [63:0] s_key = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_a = '0;
    logic [31:0] s_b = '0;
    logic [32:0] s_r = '0;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [63:0] s_rkey;
    logic [2:0]  s_vec;
    logic [2:0]  s_err;
    logic [8:0]  s_sum;
    logic [5:0]  s_max;
    logic        s_busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    locked_adder_resp_checker #(
        .WIDTH(32), .KEY_W(64), .NVEC(4), .CNT_W(16), .HD_W(6)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .key_i(key),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .add1_i(add1), .add2_i(add2), .result_i(result),
        .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready),
        .rpt_key_o(rpt_key), .rpt_vec_cnt_o(rpt_vec), .rpt_err_cnt_o(rpt_err),
        .rpt_hd_sum_o(rpt_sum), .rpt_hd_max_o(rpt_max), .busy_o(busy)
    );

    locked_adder_resp_checker #(
        .WIDTH(32), .KEY_W(64), .NVEC(7), .CNT_W(3), .HD_W(6)
    ) u_small (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .key_i(s_key),
        .in_valid_i(s_valid), .in_ready_o(s_ready),
        .add1_i(s_a), .add2_i(s_b), .result_i(s_r),
        .rpt_valid_o(s_rvalid), .rpt_ready_i(s_rready),
        .rpt_key_o(s_rkey), .rpt_vec_cnt_o(s_vec), .rpt_err_cnt_o(s_err),
        .rpt_hd_sum_o(s_sum), .rpt_hd_max_o(s_max), .busy_o(s_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All driving happens at negedges; each task is entered and left at a negedge.
    task automatic open_win(input logic [63:0] k);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic [32:0] r);
        in_valid = 1'b1;
        add1 = a;
        add2 = b;
        result = r;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take_report();
        rpt_ready = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0;
    endtask

    task automatic chk_report(input string tag, input logic [63:0] k, input int v,
                              input int e, input int s, input int m);
        chk({tag, "_valid"}, {63'd0, rpt_valid}, 64'd1);
        chk({tag, "_key"}, rpt_key, k);
        chk({tag, "_vec"}, 64'(rpt_vec), 64'(v));
        chk({tag, "_err"}, 64'(rpt_err), 64'(e));
        chk({tag, "_sum"}, 64'(rpt_sum), 64'(s));
        chk({tag, "_max"}, 64'(rpt_max), 64'(m));
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_rpt_valid", {63'd0, rpt_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_vec", 64'(rpt_vec), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: exact sums, no errors
        open_win(64'h9BA22E7333C96CAE);
        chk("t1_in_ready", {63'd0, in_ready}, 64'd1);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        beat(32'hFFFFFFFF, 32'h00000001, 33'h1_0000_0000);
        beat(32'h12345678, 32'h87654321, 33'h0_9999_9999);
        beat(32'h00000000, 32'h00000000, 33'h0_0000_0000);
        beat(32'h80000000, 32'h80000000, 33'h1_0000_0000);
        chk("t1_in_ready_after", {63'd0, in_ready}, 64'd0);
        chk_report("t1", 64'h9BA22E7333C96CAE, 4, 0, 0, 0);
        take_report();
        chk("t1_idle_valid", {63'd0, rpt_valid}, 64'd0);
        chk("t1_idle_busy", {63'd0, busy}, 64'd0);

        // Test 2: injected bit errors (hd 1,0,3,0)
        open_win(64'h0000_0000_0000_0002);
        beat(32'd1, 32'd2, 33'h0_0000_0002);
        beat(32'd5, 32'd5, 33'h0_0000_000A);
        beat(32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0_FFFF_FFFD);
        beat(32'd7, 32'd0, 33'h0_0000_0007);
        chk_report("t2", 64'h2, 4, 2, 4, 3);
        take_report();

        // Test 3: stalls between beats and back-pressured report
        open_win(64'hA5A5_0000_0000_0003);
        beat(32'd1, 32'd2, 33'h0_0000_0002);
        chk("t3_stall_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        chk("t3_stall_vec", 64'(rpt_vec), 64'd1);
        beat(32'd5, 32'd5, 33'h0_0000_000A);
        @(negedge clk);
        beat(32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0_FFFF_FFFD);
        @(negedge clk);
        chk("t3_vec3", 64'(rpt_vec), 64'd3);
        chk("t3_ready3", {63'd0, in_ready}, 64'd1);
        beat(32'd7, 32'd0, 33'h0_0000_0007);
        chk("t3_ready_off", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;    // further offered beats must be ignored
            chk_report($sformatf("t3_hold%0d", i), 64'hA5A5_0000_0000_0003, 4, 2, 4, 3);
            @(negedge clk);
        end
        in_valid = 1'b0;
        take_report();
        chk("t3_idle_valid", {63'd0, rpt_valid}, 64'd0);
        chk("t3_idle_busy", {63'd0, busy}, 64'd0);
        chk("t3_vec_kept", 64'(rpt_vec), 64'd4);

        // Test 4: asynchronous reset mid-window
        open_win(64'h4444);
        beat(32'd1, 32'd1, 33'h0_0000_0002);
        beat(32'd2, 32'd2, 33'h0_0000_0005);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("t4_rst_busy", {63'd0, busy}, 64'd0);
        chk("t4_rst_valid", {63'd0, rpt_valid}, 64'd0);
        chk("t4_rst_vec", 64'(rpt_vec), 64'd0);
        chk("t4_rst_err", 64'(rpt_err), 64'd0);
        chk("t4_rst_key", rpt_key, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_post_valid", {63'd0, rpt_valid}, 64'd0);
        chk("t4_post_ready", {63'd0, in_ready}, 64'd0);
        open_win(64'h5555);
        beat(32'd10, 32'd20, 33'h0_0000_001E);
        beat(32'd30, 32'd40, 33'h0_0000_0046);
        beat(32'd50, 32'd60, 33'h0_0000_006E);
        beat(32'd70, 32'd80, 33'h0_0000_0096);
        chk_report("t4", 64'h5555, 4, 0, 0, 0);
        take_report();

        // Test 5: start ignored in RUN and REPORT; back-to-back window
        open_win(64'h1111_2222_3333_4444);
        beat(32'd1, 32'd1, 33'h0_0000_0002);
        start = 1'b1;
        key = 64'hDEAD_BEEF_DEAD_BEEF;
        beat(32'd2, 32'd1, 33'h0_0000_0003);
        start = 1'b0;
        beat(32'd3, 32'd1, 33'h0_0000_0004);
        beat(32'd4, 32'd1, 33'h0_0000_0005);
        start = 1'b1;
        key = 64'hCAFE_CAFE_CAFE_CAFE;
        @(negedge clk);
        start = 1'b0;
        chk_report("t5", 64'h1111_2222_3333_4444, 4, 0, 0, 0);
        take_report();
        open_win(64'h7777);
        chk("t5_b2b_busy", {63'd0, busy}, 64'd1);
        chk("t5_b2b_ready", {63'd0, in_ready}, 64'd1);
        chk("t5_b2b_vec", 64'(rpt_vec), 64'd0);
        chk("t5_b2b_key", rpt_key, 64'h7777);
        beat(32'd0, 32'd0, 33'h1_FFFF_FFFF);
        beat(32'd0, 32'd0, 33'h0_0000_0000);
        beat(32'd0, 32'd0, 33'h0_0000_0000);
        beat(32'd0, 32'd0, 33'h0_0000_0000);
        chk_report("t5b", 64'h7777, 4, 1, 33, 33);
        take_report();

        // Test 6: narrow counters, every beat fully inverted (hd 33)
        s_start = 1'b1;
        s_key = 64'h6666;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_a = 32'h0101_0101 * (i + 1);
            s_b = 32'h3000_0007 + i;
            s_r = ~({1'b0, s_a} + {1'b0, s_b});
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("t6_valid", {63'd0, s_rvalid}, 64'd1);
        chk("t6_ready_off", {63'd0, s_ready}, 64'd0);
        chk("t6_vec", 64'(s_vec), 64'd7);
        chk("t6_err", 64'(s_err), 64'd7);
        chk("t6_sum", 64'(s_sum), 64'd231);
        chk("t6_max", 64'(s_max), 64'd33);
        chk("t6_key", s_rkey, 64'h6666);
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        chk("t6_idle", {63'd0, s_busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
